// File: rtl/day_of_year_encoder_pkg.sv
// rtl/day_of_year_encoder_pkg.sv - shared widths, limits and FSM encoding for the day-of-year encoder
// Contents: field widths, the last valid month number and the three-state FSM type.
package day_of_year_encoder_pkg;

    localparam int MONTH_W   = 4;
    localparam int DAY_W     = 5;
    localparam int DOY_W     = 9;
    localparam int MAX_MONTH = 12;

    // Fixed state encodings, kept as plain constants so older tools and
    // waveform decoders can reuse the same numbers.
    localparam logic [1:0] IDLE_ENC  = 2'd0;
    localparam logic [1:0] ACCUM_ENC = 2'd1;
    localparam logic [1:0] DONE_ENC  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = IDLE_ENC,
        ACCUM = ACCUM_ENC,
        DONE  = DONE_ENC
    } state_e;

endpackage

// File: rtl/day_of_year_encoder_month_length.sv
// rtl/day_of_year_encoder_month_length.sv - combinational month-length lookup
// Ports: month (1..12 valid), leap (February has 29 days when set),
//        length (days in month, 0 for any month outside 1..12).
module month_length
    import day_of_year_encoder_pkg::*;
(
    input  logic [MONTH_W-1:0] month,
    input  logic               leap,
    output logic [DAY_W-1:0]   length
);

    always_comb begin
        length = '0;
        case (month)
            4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: length = 5'd31;
            4'd4, 4'd6, 4'd9, 4'd11:                    length = 5'd30;
            4'd2:                                       length = leap ? 5'd29 : 5'd28;
            default:                                    length = 5'd0;
        endcase
    end

endmodule

// File: rtl/day_of_year_encoder.sv
// rtl/day_of_year_encoder.sv - converts a month/day/leap request into a day-of-year number
// Ports: ADC_CLK_10 clock, reset (sync, active-high), start/month/day/leap request,
//        busy (ACCUM or DONE), done (one-cycle result pulse), date_ok and doy result.
module day_of_year_encoder
    import day_of_year_encoder_pkg::*;
(
    input  logic               ADC_CLK_10,
    input  logic               reset,
    input  logic               start,
    input  logic [MONTH_W-1:0] month,
    input  logic [DAY_W-1:0]   day,
    input  logic               leap,
    output logic               busy,
    output logic               done,
    output logic               date_ok,
    output logic [DOY_W-1:0]   doy
);

    state_e             state_q, state_d;
    logic [MONTH_W-1:0] month_q, month_d;
    logic [DAY_W-1:0]   day_q, day_d;
    logic               leap_q, leap_d;
    logic [DOY_W-1:0]   acc_q, acc_d;
    logic [MONTH_W-1:0] idx_q, idx_d;
    logic [DOY_W-1:0]   doy_q, doy_d;
    logic               date_ok_q, date_ok_d;

    logic [DAY_W-1:0]   len_idx;
    logic [DAY_W-1:0]   len_month;
    logic               month_valid;
    logic               date_valid;

    // Length of the month currently being accumulated.
    month_length u_len_idx (
        .month  (idx_q),
        .leap   (leap_q),
        .length (len_idx)
    );

    // Length of the requested month, used only for validating the day.
    month_length u_len_month (
        .month  (month_q),
        .leap   (leap_q),
        .length (len_month)
    );

    assign month_valid = (month_q >= 4'd1) && (month_q <= 4'(MAX_MONTH));
    // len_month is 0 for a bad month, so a bad month also fails the day bound.
    assign date_valid  = month_valid && (day_q != '0) && (day_q <= len_month);

    always_comb begin
        state_d   = state_q;
        month_d   = month_q;
        day_d     = day_q;
        leap_d    = leap_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        doy_d     = doy_q;
        date_ok_d = date_ok_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    month_d = month;
                    day_d   = day;
                    leap_d  = leap;
                    acc_d   = '0;
                    idx_d   = 4'd1;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                // The accumulator holds the sum of months before idx_q, so once
                // idx_q reaches the requested month it is the day-of-year base.
                if ((idx_q == month_q) || !month_valid) begin
                    state_d   = DONE;
                    date_ok_d = date_valid;
                    doy_d     = date_valid ? (acc_q + {4'b0, day_q}) : '0;
                end else begin
                    acc_d = acc_q + {4'b0, len_idx};
                    idx_d = idx_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge ADC_CLK_10) begin
        if (reset) begin
            state_q   <= IDLE;
            month_q   <= '0;
            day_q     <= '0;
            leap_q    <= 1'b0;
            acc_q     <= '0;
            idx_q     <= '0;
            doy_q     <= '0;
            date_ok_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            month_q   <= month_d;
            day_q     <= day_d;
            leap_q    <= leap_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            doy_q     <= doy_d;
            date_ok_q <= date_ok_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign date_ok = date_ok_q;
    assign doy     = doy_q;

endmodule

// File: tb/tb_day_of_year_encoder.sv
// tb/tb_day_of_year_encoder.sv - self-checking bench for day_of_year_encoder
module tb_day_of_year_encoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] month;
    logic [4:0] day;
    logic       leap;
    logic       busy;
    logic       done;
    logic       date_ok;
    logic [8:0] doy;

    typedef struct {
        int doy;
        int ok;
        int lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   pulses;

    always #5 clk = ~clk;

    day_of_year_encoder dut (
        .ADC_CLK_10 (clk),
        .reset      (reset),
        .start      (start),
        .month      (month),
        .day        (day),
        .leap       (leap),
        .busy       (busy),
        .done       (done),
        .date_ok    (date_ok),
        .doy        (doy)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Drives a request sampled at edge E; returns 1ns after E.
    task automatic start_req(input int m, input int d, input int l,
                             input int edoy, input int eok, input int elat, input bit push);
        exp_t e;
        if (push) begin
            e.doy = edoy; e.ok = eok; e.lat = elat;
            exp_q.push_back(e);
        end
        month = 4'(m); day = 5'(d); leap = l[0]; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts edges after E until done; 'elapsed' edges past E have already passed.
    task automatic wait_done(input int elapsed, input bit start_in_done);
        exp_t e;
        int   lat;
        logic [8:0] held;
        lat = 0;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 16'd1, 16'd0);
            return;
        end
        e = exp_q.pop_front();
        for (int k = elapsed + 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        chk("latency", 16'(lat), 16'(e.lat));
        chk("doy", 16'(doy), 16'(e.doy));
        chk("date_ok", 16'(date_ok), 16'(e.ok));
        chk("busy_in_done", 16'(busy), 16'd1);
        held = doy;
        if (start_in_done) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("done_one_cycle", 16'(done), 16'd0);
        chk("busy_after_done", 16'(busy), 16'd0);
        chk("doy_held", 16'(doy), 16'(held));
    endtask

    task automatic count_pulses(input int cycles);
        pulses = 0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; month = '0; day = '0; leap = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_done", 16'(done), 16'd0);
        chk("rst_date_ok", 16'(date_ok), 16'd0);
        chk("rst_doy", 16'(doy), 16'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Non-leap March 1st
        start_req(3, 1, 0, 60, 1, 3, 1);
        chk("busy_after_start", 16'(busy), 16'd1);
        wait_done(0, 0);

        // Leap year end and year start
        start_req(12, 31, 1, 366, 1, 12, 1);
        wait_done(0, 0);
        start_req(1, 1, 1, 1, 1, 1, 1);
        wait_done(0, 0);

        // February 29th, non-leap then leap
        start_req(2, 29, 0, 0, 0, 2, 1);
        wait_done(0, 0);
        start_req(2, 29, 1, 60, 1, 2, 1);
        wait_done(0, 0);

        // Invalid month and day values
        start_req(13, 5, 0, 0, 0, 1, 1);
        wait_done(0, 0);
        start_req(0, 5, 0, 0, 0, 1, 1);
        wait_done(0, 0);
        start_req(4, 31, 0, 0, 0, 4, 1);
        wait_done(0, 0);
        start_req(5, 0, 0, 0, 0, 5, 1);
        wait_done(0, 0);

        // Busy handling: inputs change for E+1, start pulsed at E+2 and in DONE
        start_req(6, 15, 0, 166, 1, 6, 1);
        month = 4'd2; day = 5'd29; leap = 1'b1;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(2, 1);
        count_pulses(10);
        chk("no_extra_done", 16'(pulses), 16'd0);

        // Mid-operation reset at E+4 of an October conversion
        start_req(10, 20, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_busy", 16'(busy), 16'd0);
        chk("abort_done", 16'(done), 16'd0);
        chk("abort_doy", 16'(doy), 16'd0);
        chk("abort_date_ok", 16'(date_ok), 16'd0);
        count_pulses(15);
        chk("abort_no_done", 16'(pulses), 16'd0);

        // Fresh conversion after the abort
        start_req(10, 20, 0, 293, 1, 10, 1);
        wait_done(0, 0);

        chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/day_of_year_encoder.md
DAY_OF_YEAR_ENCODER -- requirements
Module: day_of_year_encoder

Interface
REQ-001 The block SHALL have these ports, clock and reset first:
- ADC_CLK_10, input, 1: sole clock; all state changes on its rising edge.
- reset, input, 1: synchronous, active-high.
- start, input, 1: request to convert; sampled only in IDLE.
- month, input, 4: month number; 1..12 valid.
- day, input, 5: day of month; 1..31 range.
- leap, input, 1: 1 means February has 29 days, else 28 (same role as the SW year-select switches).
- busy, output, 1: high while a conversion is in progress.
- done, output, 1: one-cycle pulse marking result update.
- date_ok, output, 1: 1 when the last converted date was valid.
- doy, output, 9: day of year 1..366 for a valid date, 0 otherwise.
REQ-002 The block SHALL have no parameters; all widths are fixed as listed above.

Function
REQ-003 The FSM SHALL have three states:
- IDLE -> ACCUM when start=1.
- ACCUM -> DONE on the exit condition in REQ-005.
- DONE -> IDLE unconditionally after one cycle.
REQ-004 On the start edge E in IDLE, the block SHALL latch month, day and leap, clear the accumulator (9 bits), and set the month index to 1.
REQ-005 In ACCUM, each cycle the block SHALL add length(index) to the accumulator and increment the index, until index equals the latched month or the latched month is outside 1..12; in that case the next state is DONE.
REQ-006 Month lengths SHALL be 31,28/29,31,30,31,30,31,31,30,31,30,31; February uses the latched leap value.
REQ-007 Latency: for a valid month M, done SHALL be high for exactly the one cycle following edge E+M. For an invalid month, done SHALL follow edge E+1.
REQ-008 Date validation SHALL be: date_ok=1 iff 1<=month<=12 and 1<=day<=length(month).
REQ-009 Result when done is high:
- valid date: doy = accumulator + day.
- invalid date: doy = 0 and date_ok = 0.
REQ-010 doy and date_ok SHALL update only on the edge that enters DONE, and hold until the next DONE.
REQ-011 busy SHALL be 1 in ACCUM and DONE, and 0 in IDLE.
REQ-012 start asserted while busy=1 SHALL be ignored, with no queueing. start asserted in the DONE cycle is also ignored.
REQ-013 Changes to month, day or leap after edge E SHALL NOT affect the conversion in progress.
REQ-014 The accumulator SHALL never exceed 335 and doy SHALL never exceed 366; no wrap-around is possible.

Reset
REQ-015 When reset=1 at a rising edge, the block SHALL:
- go to IDLE;
- set busy=0, done=0, date_ok=0, doy=0;
- clear the accumulator and index.
REQ-016 Reset SHALL take priority over start and over any in-progress conversion; an aborted conversion produces no done pulse.

Structure
REQ-017 A shared package SHALL hold:
- the state enum (IDLE, ACCUM, DONE);
- the widths MONTH_W=4, DAY_W=5, DOY_W=9;
- the constant MAX_MONTH=12.
REQ-018 The month-length lookup SHALL be one combinational sub-module, month_length (inputs month and leap, output 5-bit length 0 for invalid month). It is instantiated twice: once for the accumulation index and once for validation of the latched month.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Non-leap March: month=3, day=1, leap=0, start at E -> done after E+3, doy=60, date_ok=1.
- Leap year-end: month=12, day=31, leap=1 -> done after E+12, doy=366; month=1, day=1 -> done after E+1, doy=1.
- Invalid February: month=2, day=29, leap=0 -> doy=0, date_ok=0. Same request with leap=1 -> doy=60, date_ok=1.
- Invalid month/day: month=13 -> done after E+1, doy=0, date_ok=0. month=4, day=31 -> doy=0. day=0 -> doy=0.
- Busy handling: start pulsed at E+2 during a month=6 conversion, and inputs changed at E+1 -> ignored; a single done after E+6 with the originally latched result.
- Mid-operation reset: reset at E+4 of a month=10 conversion -> IDLE next cycle, busy=0, doy=0, no done; a new start then converts normally.
